// File: rtl/dmem_port_pkg.sv
// Shared types and helpers for the data-memory access controller:
// load/store opcodes, controller states and store-lane formatting.
package dmem_port_pkg;

    typedef enum logic [3:0] {
        i_NONE = 4'd0,
        i_LB   = 4'd1,
        i_LH   = 4'd2,
        i_LW   = 4'd3,
        i_LBU  = 4'd4,
        i_LHU  = 4'd5,
        i_SB   = 4'd6,
        i_SH   = 4'd7,
        i_SW   = 4'd8
    } ls_op_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } dmem_state_t;

    function automatic logic is_load(input ls_op_t op);
        return (op == i_LB) || (op == i_LH) || (op == i_LW) ||
               (op == i_LBU) || (op == i_LHU);
    endfunction

    function automatic logic is_store(input ls_op_t op);
        return (op == i_SB) || (op == i_SH) || (op == i_SW);
    endfunction

    function automatic logic is_misaligned(input ls_op_t op, input logic [1:0] a);
        case (op)
            i_LH, i_LHU, i_SH: return a[0];
            i_LW, i_SW:        return a != 2'b00;
            default:           return 1'b0;
        endcase
    endfunction

    function automatic logic [3:0] store_strb(input ls_op_t op, input logic [1:0] a);
        case (op)
            i_SB:    return 4'b0001 << a;
            i_SH:    return 4'b0011 << a;
            i_SW:    return 4'b1111;
            default: return 4'b0000;
        endcase
    endfunction

    function automatic logic [31:0] store_data(input ls_op_t op, input logic [31:0] d);
        case (op)
            i_SB:    return {4{d[7:0]}};
            i_SH:    return {2{d[15:0]}};
            default: return d;
        endcase
    endfunction

endpackage

// File: rtl/dmem_port_load_extract.sv
// Combinational load-data alignment: selects the addressed byte/half of the
// bus word and sign- or zero-extends it.
module load_extract
    import dmem_port_pkg::*;
(
    input  ls_op_t      i_op,
    input  logic [1:0]  i_addr_lo,
    input  logic [31:0] i_rdata,
    output logic [31:0] o_data
);

    logic [7:0]  w_bytes [4];
    logic [7:0]  w_byte;
    logic [15:0] w_half;

    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
        assign w_bytes[gi] = i_rdata[8*gi +: 8];
    end

    assign w_byte = w_bytes[i_addr_lo];
    assign w_half = i_addr_lo[1] ? i_rdata[31:16] : i_rdata[15:0];

    always_comb begin
        o_data = i_rdata;
        case (i_op)
            i_LB:    o_data = {{24{w_byte[7]}}, w_byte};
            i_LBU:   o_data = {24'd0, w_byte};
            i_LH:    o_data = {{16{w_half[15]}}, w_half};
            i_LHU:   o_data = {16'd0, w_half};
            default: o_data = i_rdata;
        endcase
    end

endmodule

// File: rtl/dmem_port.sv
// Single-outstanding load/store bus controller: alignment check, byte strobes,
// request/ack handshake with timeout, and extended load writeback.
module dmem_port
    import dmem_port_pkg::*;
#(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  ls_op_t      ls_op,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [4:0]  req_rd,
    output logic        busy,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_wstrb,
    output logic [31:0] bus_wdata,
    input  logic        bus_ack,
    input  logic [31:0] bus_rdata,
    input  logic        bus_err,
    output logic        wb_valid,
    output logic [4:0]  wb_rd,
    output logic [31:0] wb_data,
    output logic        done,
    output logic        misalign_exc,
    output logic        access_fault,
    output logic [31:0] fault_addr
);

    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    dmem_state_t r_state, w_state_next;
    ls_op_t      r_op;
    logic [31:0] r_addr, r_wdata, r_rdata;
    logic [4:0]  r_rd;
    logic [3:0]  r_wstrb;
    logic        r_misalign, r_fault;
    logic [CW-1:0] r_cnt;

    logic        w_accept, w_misalign, w_timeout, w_in_req, w_in_done;
    logic [31:0] w_ext;

    assign w_accept   = req_valid && (r_state == IDLE) && (is_load(ls_op) || is_store(ls_op));
    assign w_misalign = is_misaligned(ls_op, req_addr[1:0]);
    assign w_timeout  = (TIMEOUT != 0) && (r_cnt == CW'(TIMEOUT - 1));
    assign w_in_req   = (r_state == REQ);
    assign w_in_done  = (r_state == DONE);

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (w_accept) w_state_next = w_misalign ? DONE : REQ;
            REQ:     if (bus_ack || w_timeout) w_state_next = DONE;
            DONE:    w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_op       <= i_NONE;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_rdata    <= '0;
            r_rd       <= '0;
            r_wstrb    <= '0;
            r_misalign <= 1'b0;
            r_fault    <= 1'b0;
            r_cnt      <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_accept) begin
                r_op       <= ls_op;
                r_addr     <= req_addr;
                r_rd       <= req_rd;
                r_wstrb    <= store_strb(ls_op, req_addr[1:0]);
                r_wdata    <= store_data(ls_op, req_wdata);
                r_misalign <= w_misalign;
                r_fault    <= 1'b0;
                r_cnt      <= '0;
            end else if (w_in_req) begin
                // An ack in the last allowed cycle takes precedence over the timeout.
                if (bus_ack) begin
                    r_fault <= bus_err;
                    if (is_load(r_op) && !bus_err)
                        r_rdata <= bus_rdata;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                    if (w_timeout)
                        r_fault <= 1'b1;
                end
            end
        end
    end

    load_extract u_extract (
        .i_op      (r_op),
        .i_addr_lo (r_addr[1:0]),
        .i_rdata   (r_rdata),
        .o_data    (w_ext)
    );

    assign req_ready    = (r_state == IDLE);
    assign busy         = !req_ready;
    assign bus_req      = w_in_req;
    assign bus_we       = w_in_req && is_store(r_op);
    assign bus_addr     = w_in_req ? {r_addr[31:2], 2'b00} : 32'd0;
    assign bus_wstrb    = w_in_req ? r_wstrb : 4'd0;
    assign bus_wdata    = w_in_req ? r_wdata : 32'd0;
    assign done         = w_in_done;
    assign misalign_exc = w_in_done && r_misalign;
    assign access_fault = w_in_done && r_fault;
    assign wb_valid     = w_in_done && is_load(r_op) && !r_misalign && !r_fault;
    assign wb_rd        = wb_valid ? r_rd : 5'd0;
    assign wb_data      = wb_valid ? w_ext : 32'd0;
    assign fault_addr   = (misalign_exc || access_fault) ? r_addr : 32'd0;

endmodule

// File: tb/tb_dmem_port.sv
// Directed bench for dmem_port with a 4-cycle timeout: loads, stores, lane
// handling, misalignment, bus error, timeout and mid-transfer reset.
module tb_dmem_port;
    import dmem_port_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    ls_op_t      ls_op = i_NONE;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic [4:0]  req_rd = '0;
    logic        busy, bus_req, bus_we;
    logic [31:0] bus_addr, bus_wdata;
    logic [3:0]  bus_wstrb;
    logic        bus_ack = 1'b0;
    logic [31:0] bus_rdata = '0;
    logic        bus_err = 1'b0;
    logic        wb_valid, done, misalign_exc, access_fault;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data, fault_addr;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    dmem_port #(.TIMEOUT(4)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .ls_op(ls_op), .req_addr(req_addr), .req_wdata(req_wdata), .req_rd(req_rd),
        .busy(busy), .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
        .bus_wstrb(bus_wstrb), .bus_wdata(bus_wdata), .bus_ack(bus_ack),
        .bus_rdata(bus_rdata), .bus_err(bus_err), .wb_valid(wb_valid), .wb_rd(wb_rd),
        .wb_data(wb_data), .done(done), .misalign_exc(misalign_exc),
        .access_fault(access_fault), .fault_addr(fault_addr)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input ls_op_t op, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [4:0] rd);
        req_valid = 1'b1;
        ls_op     = op;
        req_addr  = addr;
        req_wdata = wdata;
        req_rd    = rd;
        step();
        req_valid = 1'b0;
        ls_op     = i_NONE;
    endtask

    // Acked transaction after 'waits' idle REQ cycles.
    task automatic bus_txn(input string name, input ls_op_t op, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [4:0] rd, input int waits,
                           input logic err, input logic [31:0] rdata, input logic [3:0] exp_strb,
                           input logic [31:0] exp_wdata, input logic exp_wbv,
                           input logic [31:0] exp_wbdata);
        logic st;
        st = (op == i_SB) || (op == i_SH) || (op == i_SW);
        issue(op, addr, wdata, rd);
        for (int i = 0; i <= waits; i++) begin
            check_eq({name, ".bus_req"}, 32'(bus_req), 32'd1);
            check_eq({name, ".req_ready"}, 32'(req_ready), 32'd0);
            check_eq({name, ".bus_addr"}, bus_addr, {addr[31:2], 2'b00});
            check_eq({name, ".bus_we"}, 32'(bus_we), 32'(st));
            check_eq({name, ".bus_wstrb"}, 32'(bus_wstrb), 32'(exp_strb));
            if (st) check_eq({name, ".bus_wdata"}, bus_wdata, exp_wdata);
            check_eq({name, ".done_early"}, 32'(done), 32'd0);
            if (i == waits) begin
                bus_ack   = 1'b1;
                bus_err   = err;
                bus_rdata = rdata;
            end else begin
                bus_rdata = 32'h5A5A5A5A;
            end
            step();
        end
        bus_ack = 1'b0;
        bus_err = 1'b0;
        check_eq({name, ".done"}, 32'(done), 32'd1);
        check_eq({name, ".bus_req_off"}, 32'(bus_req), 32'd0);
        check_eq({name, ".wb_valid"}, 32'(wb_valid), 32'(exp_wbv));
        check_eq({name, ".access_fault"}, 32'(access_fault), 32'(err));
        check_eq({name, ".misalign"}, 32'(misalign_exc), 32'd0);
        if (exp_wbv) begin
            check_eq({name, ".wb_data"}, wb_data, exp_wbdata);
            check_eq({name, ".wb_rd"}, 32'(wb_rd), 32'(rd));
        end
        if (err) check_eq({name, ".fault_addr"}, fault_addr, addr);
        step();
        check_eq({name, ".req_ready"}, 32'(req_ready), 32'd1);
        check_eq({name, ".done_clr"}, 32'(done), 32'd0);
        $display("[TB] txn %s addr=0x%08h waits=%0d err=%0d", name, addr, waits, err);
    endtask

    task automatic misalign_txn(input string name, input ls_op_t op, input logic [31:0] addr);
        issue(op, addr, 32'hFFFF_FFFF, 5'd3);
        check_eq({name, ".misalign"}, 32'(misalign_exc), 32'd1);
        check_eq({name, ".done"}, 32'(done), 32'd1);
        check_eq({name, ".fault_addr"}, fault_addr, addr);
        check_eq({name, ".bus_req"}, 32'(bus_req), 32'd0);
        check_eq({name, ".wb_valid"}, 32'(wb_valid), 32'd0);
        check_eq({name, ".access_fault"}, 32'(access_fault), 32'd0);
        step();
        check_eq({name, ".req_ready"}, 32'(req_ready), 32'd1);
        check_eq({name, ".bus_req2"}, 32'(bus_req), 32'd0);
        $display("[TB] txn %s addr=0x%08h misaligned", name, addr);
    endtask

    initial begin
        step();
        step();
        check_eq("rst.req_ready", 32'(req_ready), 32'd1);
        check_eq("rst.busy", 32'(busy), 32'd0);
        check_eq("rst.bus_req", 32'(bus_req), 32'd0);
        check_eq("rst.done", 32'(done), 32'd0);
        check_eq("rst.wb_valid", 32'(wb_valid), 32'd0);
        check_eq("rst.bus_wstrb", 32'(bus_wstrb), 32'd0);
        check_eq("rst.fault_addr", fault_addr, 32'd0);
        rst = 1'b0;
        step();

        // name        op     addr        wdata         rd  w e rdata         strb     wdata         wbv wbdata
        bus_txn("lw",   i_LW,  32'h100, 32'h0,        5'd5, 0, 0, 32'hDEADBEEF, 4'b0000, 32'h0,        1, 32'hDEADBEEF);
        bus_txn("lb",   i_LB,  32'h103, 32'h0,        5'd6, 0, 0, 32'h80123456, 4'b0000, 32'h0,        1, 32'hFFFFFF80);
        bus_txn("lbu",  i_LBU, 32'h103, 32'h0,        5'd7, 0, 0, 32'h80123456, 4'b0000, 32'h0,        1, 32'h00000080);
        bus_txn("lb1",  i_LB,  32'h101, 32'h0,        5'd8, 1, 0, 32'h80127F56, 4'b0000, 32'h0,        1, 32'h0000007F);
        bus_txn("lh",   i_LH,  32'h102, 32'h0,        5'd9, 0, 0, 32'h80017FFF, 4'b0000, 32'h0,        1, 32'hFFFF8001);
        bus_txn("lhu",  i_LHU, 32'h102, 32'h0,        5'd10,0, 0, 32'h80017FFF, 4'b0000, 32'h0,        1, 32'h00008001);
        bus_txn("lh0",  i_LH,  32'h100, 32'h0,        5'd11,0, 0, 32'h8001F00F, 4'b0000, 32'h0,        1, 32'hFFFFF00F);
        bus_txn("sh",   i_SH,  32'h202, 32'h1234ABCD, 5'd12,3, 0, 32'h0,        4'b1100, 32'hABCDABCD, 0, 32'h0);
        bus_txn("sb",   i_SB,  32'h301, 32'h000000A5, 5'd13,0, 0, 32'h0,        4'b0010, 32'hA5A5A5A5, 0, 32'h0);
        bus_txn("sw",   i_SW,  32'h400, 32'hCAFEF00D, 5'd14,1, 0, 32'h0,        4'b1111, 32'hCAFEF00D, 0, 32'h0);
        bus_txn("lwerr",i_LW,  32'h500, 32'h0,        5'd15,0, 1, 32'h11111111, 4'b0000, 32'h0,        0, 32'h0);

        misalign_txn("mis_lw", i_LW, 32'h101);
        misalign_txn("mis_sh", i_SH, 32'h203);
        misalign_txn("mis_sw", i_SW, 32'h402);

        // Non-memory op with req_valid is ignored.
        req_valid = 1'b1;
        ls_op     = ls_op_t'(4'd12);
        step();
        req_valid = 1'b0;
        ls_op     = i_NONE;
        check_eq("nop.req_ready", 32'(req_ready), 32'd1);
        check_eq("nop.bus_req", 32'(bus_req), 32'd0);
        step();
        check_eq("nop.done", 32'(done), 32'd0);
        $display("[TB] txn nop ignored");

        // Timeout: 4 REQ cycles without ack, then a faulting DONE.
        issue(i_LW, 32'h600, 32'h0, 5'd4);
        for (int i = 0; i < 4; i++) begin
            check_eq("tmo.bus_req", 32'(bus_req), 32'd1);
            check_eq("tmo.done_early", 32'(done), 32'd0);
            step();
        end
        check_eq("tmo.access_fault", 32'(access_fault), 32'd1);
        check_eq("tmo.done", 32'(done), 32'd1);
        check_eq("tmo.wb_valid", 32'(wb_valid), 32'd0);
        check_eq("tmo.bus_req_off", 32'(bus_req), 32'd0);
        check_eq("tmo.fault_addr", fault_addr, 32'h600);
        step();
        check_eq("tmo.req_ready", 32'(req_ready), 32'd1);
        check_eq("tmo.bus_req_after", 32'(bus_req), 32'd0);
        $display("[TB] txn timeout addr=0x00000600");

        // Reset during the second REQ cycle, then a stray ack.
        issue(i_LW, 32'h700, 32'h0, 5'd2);
        check_eq("rstreq.bus_req1", 32'(bus_req), 32'd1);
        step();
        check_eq("rstreq.bus_req2", 32'(bus_req), 32'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check_eq("rstreq.req_ready", 32'(req_ready), 32'd1);
        check_eq("rstreq.busy", 32'(busy), 32'd0);
        check_eq("rstreq.bus_req", 32'(bus_req), 32'd0);
        check_eq("rstreq.done", 32'(done), 32'd0);
        check_eq("rstreq.bus_addr", bus_addr, 32'd0);
        bus_ack   = 1'b1;
        bus_rdata = 32'h99999999;
        step();
        bus_ack = 1'b0;
        check_eq("late_ack.done", 32'(done), 32'd0);
        check_eq("late_ack.wb_valid", 32'(wb_valid), 32'd0);
        check_eq("late_ack.busy", 32'(busy), 32'd0);
        $display("[TB] txn reset_in_req addr=0x00000700");

        // Controller still works after the abandoned transfer.
        bus_txn("lw_post", i_LW, 32'h704, 32'h0, 5'd1, 0, 0, 32'h0BADF00D, 4'b0000, 32'h0, 1, 32'h0BADF00D);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
